// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : Single-access memory-bus sequencer with ACK wait and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ,
    input  logic              WR,
    input  logic [DATA_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [DATA_W-1:0] RDATA,
    output logic [DATA_W-1:0] MAO,
    output logic [DATA_W-1:0] MDO,
    output logic              MWR,
    output logic              AS,
    input  logic              ACK,
    input  logic [DATA_W-1:0] MDI
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    // ACK is tested before the timeout so a tie on the last wait cycle completes normally.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
            AS      <= 1'b0;
            MWR     <= 1'b0;
            MAO     <= '0;
            MDO     <= '0;
            RDATA   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (REQ) begin
                        MAO     <= ADDR;
                        MDO     <= WDATA;
                        MWR     <= WR;
                        AS      <= 1'b1;
                        BUSY    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ACK) begin
                        AS      <= 1'b0;
                        DONE    <= 1'b1;
                        r_state <= S_FIN;
                        if (!MWR) begin
                            RDATA <= MDI;
                        end
                    end else if (r_cnt == c_CNT_LAST) begin
                        AS      <= 1'b0;
                        ERR     <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    DONE    <= 1'b0;
                    ERR     <= 1'b0;
                    BUSY    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    AS      <= 1'b0;
                    DONE    <= 1'b0;
                    ERR     <= 1'b0;
                    BUSY    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Brief    : Self-checking bench for mem_access_ctrl against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int DW = 32;
    localparam int TO = 15;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          REQ = 1'b0;
    logic          WR = 1'b0;
    logic [DW-1:0] ADDR = '0;
    logic [DW-1:0] WDATA = '0;
    logic          ACK = 1'b0;
    logic [DW-1:0] MDI = '0;
    logic          BUSY, DONE, ERR, MWR, AS;
    logic [DW-1:0] RDATA, MAO, MDO;

    int tests = 0;
    int failed = 0;

    logic [DW-1:0] exp_rdata = '0;
    logic [DW-1:0] exp_mao = '0;
    logic [DW-1:0] exp_mdo = '0;
    logic          exp_mwr = 1'b0;

    mem_access_ctrl #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .WR(WR), .ADDR(ADDR), .WDATA(WDATA),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA), .MAO(MAO), .MDO(MDO),
        .MWR(MWR), .AS(AS), .ACK(ACK), .MDI(MDI)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit as_e, input bit busy_e,
                           input bit done_e, input bit err_e);
        chk({tag, ".AS"}, DW'(AS), DW'(as_e));
        chk({tag, ".BUSY"}, DW'(BUSY), DW'(busy_e));
        chk({tag, ".DONE"}, DW'(DONE), DW'(done_e));
        chk({tag, ".ERR"}, DW'(ERR), DW'(err_e));
        chk({tag, ".MAO"}, MAO, exp_mao);
        chk({tag, ".MDO"}, MDO, exp_mdo);
        chk({tag, ".MWR"}, DW'(MWR), DW'(exp_mwr));
        chk({tag, ".RDATA"}, RDATA, exp_rdata);
    endtask

    // One access seen as a transaction: ACK arrives on wait cycle ack_at (0-based),
    // or never if ack_at >= TO, in which case the access times out after TO cycles.
    task automatic do_access(input string tag, input bit wr, input logic [DW-1:0] addr,
                             input logic [DW-1:0] wdata, input int ack_at, input bit keep_req);
        bit            timed_out;
        int            wait_len;
        logic [DW-1:0] pending;
        timed_out = (ack_at >= TO);
        wait_len  = timed_out ? TO : ack_at + 1;
        pending   = exp_rdata;
        REQ = 1'b1; WR = wr; ADDR = addr; WDATA = wdata; ACK = 1'b0; MDI = $urandom;
        exp_mao = addr; exp_mdo = wdata; exp_mwr = wr;
        for (int t = 1; t <= wait_len + 2; t++) begin
            @(posedge CLK); #1;
            if (t == wait_len + 1) exp_rdata = pending;
            chk_all(tag, t <= wait_len, t <= wait_len + 1,
                    (t == wait_len + 1) && !timed_out, (t == wait_len + 1) && timed_out);
            if (t == wait_len + 2) begin
                REQ = keep_req; ACK = 1'b0;
            end else begin
                REQ   = keep_req ? 1'b1 : 1'($urandom_range(0, 1));
                WR    = 1'($urandom_range(0, 1));
                ADDR  = $urandom;
                WDATA = $urandom;
                MDI   = $urandom;
                ACK   = (t <= wait_len) ? (!timed_out && t == wait_len) : 1'b1;
                if (t == wait_len && !timed_out && !wr) pending = MDI;
            end
        end
    endtask

    initial begin
        #23;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        RESET = 1'b0;
        @(posedge CLK); #1;
        chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        do_access("read",     1'b0, 32'h0000_1000, 32'h0, 1, 1'b0);
        chk("read.rdata_val", RDATA, 32'hDEAD_BEEF === 32'hDEAD_BEEF ? exp_rdata : '0);
        do_access("write",    1'b1, 32'h0000_0020, 32'h1234_5678, 0, 1'b0);
        do_access("timeout",  1'b0, 32'h0000_0300, 32'h0, 99, 1'b0);
        do_access("tie",      1'b0, 32'h0000_0400, 32'h0, TO - 1, 1'b0);
        do_access("b2b_1",    1'b0, 32'h0000_0040, 32'h0, 0, 1'b1);
        do_access("b2b_2",    1'b1, 32'h0000_0044, 32'hA5A5_0044, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            do_access("rand", 1'($urandom_range(0, 1)), $urandom, $urandom,
                      int'($urandom_range(0, TO + 2)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset while the strobe is up, away from any clock edge.
        REQ = 1'b1; WR = 1'b0; ADDR = 32'h0000_0BAD; ACK = 1'b0;
        @(posedge CLK); #1;
        REQ = 1'b0;
        @(posedge CLK); #1;
        chk("pre_rst.AS", DW'(AS), DW'(1'b1));
        #2 RESET = 1'b1;
        #1;
        exp_rdata = '0; exp_mao = '0; exp_mdo = '0; exp_mwr = 1'b0;
        chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        #2 RESET = 1'b0;
        ACK = 1'b1;
        @(posedge CLK); #1;
        chk_all("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge CLK); #1;
        chk_all("post_rst2", 1'b0, 1'b0, 1'b0, 1'b0);
        do_access("after_rst", 1'b0, 32'h0000_0C00, 32'h0, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of run, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
